// File: rtl/paralelo_serial_tx.sv
// Byte-framed parallel-to-serial transmitter on clk_32f: sends COM until sync completes, then data or IDLE, MSB first.
// Optional PARALELO_SERIAL_STATS_EN adds saturating data/idle byte counters.
module paralelo_serial_tx #(
    parameter int unsigned SYNC_COUNT = 4,
    parameter logic [7:0]  COM_SYM    = 8'hBC,
    parameter logic [7:0]  IDLE_SYM   = 8'h7C
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    input  logic        active_in,
    output logic        data_taken,
    output logic        serial_out,
    output logic        active_out
`ifdef PARALELO_SERIAL_STATS_EN
    ,
    output logic [15:0] data_count,
    output logic [15:0] idle_count
`endif
);

    typedef enum logic [0:0] {
        ST_COM    = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic [3:0] SYNC_CNT = 4'(SYNC_COUNT);

    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    state_t     state_q, state_d;

    logic       boundary_s;
    logic       sync_done_s;
    logic       load_data_s;
    logic       load_idle_s;

    assign boundary_s  = (bit_cnt_q == 3'd7);
    assign sync_done_s = (com_cnt_q == SYNC_CNT);

    // Next-state: shift between boundaries, pick the next symbol on a boundary
    always_comb begin
        state_d     = state_q;
        shreg_d     = {shreg_q[6:0], 1'b0};
        bit_cnt_d   = bit_cnt_q + 3'd1;
        com_cnt_d   = com_cnt_q;
        load_data_s = 1'b0;
        load_idle_s = 1'b0;
        if (boundary_s) begin
            case (state_q)
                ST_COM: begin
                    if (sync_done_s && active_in) begin
                        state_d = ST_ACTIVE;
                        if (valid_in) begin
                            shreg_d     = data_in;
                            load_data_s = 1'b1;
                        end else begin
                            shreg_d     = IDLE_SYM;
                            load_idle_s = 1'b1;
                        end
                    end else begin
                        shreg_d = COM_SYM;
                        if (com_cnt_q < SYNC_CNT) begin
                            com_cnt_d = com_cnt_q + 4'd1;
                        end else begin
                            com_cnt_d = com_cnt_q;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (!active_in) begin
                        // Losing permission drops straight back to sync; that COM counts as the first
                        state_d   = ST_COM;
                        shreg_d   = COM_SYM;
                        com_cnt_d = 4'd1;
                    end else if (valid_in) begin
                        shreg_d     = data_in;
                        load_data_s = 1'b1;
                    end else begin
                        shreg_d     = IDLE_SYM;
                        load_idle_s = 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_COM;
                    shreg_d   = COM_SYM;
                    com_cnt_d = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            shreg_q   <= 8'h00;
            bit_cnt_q <= 3'd7;
            com_cnt_q <= 4'd0;
            state_q   <= ST_COM;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            state_q   <= state_d;
        end
    end

    assign serial_out = shreg_q[7];
    assign active_out = (state_q == ST_ACTIVE);
    assign data_taken = load_data_s && !reset;

`ifdef PARALELO_SERIAL_STATS_EN
    logic [15:0] data_count_q, data_count_d;
    logic [15:0] idle_count_q, idle_count_d;

    // Saturating byte-type counters
    always_comb begin
        data_count_d = data_count_q;
        idle_count_d = idle_count_q;
        if (load_data_s && (data_count_q != 16'hFFFF)) begin
            data_count_d = data_count_q + 16'd1;
        end else begin
            data_count_d = data_count_q;
        end
        if (load_idle_s && (idle_count_q != 16'hFFFF)) begin
            idle_count_d = idle_count_q + 16'd1;
        end else begin
            idle_count_d = idle_count_q;
        end
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            data_count_q <= 16'd0;
            idle_count_q <= 16'd0;
        end else begin
            data_count_q <= data_count_d;
            idle_count_q <= idle_count_d;
        end
    end

    assign data_count = data_count_q;
    assign idle_count = idle_count_q;
`endif

endmodule
